// File: rtl/ship_placer_grid_if.sv
`default_nettype none
// ============================================================================
// Module   : ship_placer_grid_if
// Purpose  : Bundles the control, placement-request and board signals that
//            connect the ship placer to its environment.
// Ports    : master - drives enable/num_ships/init_grid/place/row/col/orient,
//                     observes grid/busy/placed/reject/ships_left/done
//            slave  - the ship placer side (directions reversed)
// Config   : SHIP_VERTICAL_EN (consumed by ship_placer_grid; the signal
//            list here is identical with or without it)
// Revision : 1.0 - initial release
// ============================================================================
interface ship_placer_grid_if #(
    parameter int GRID_N   = 5,
    parameter int MAX_SHIP = 5
);
    localparam int CELL_W = $clog2(MAX_SHIP + 1);
    localparam int IDX_W  = $clog2(GRID_N);
    localparam int GRID_W = GRID_N * GRID_N * CELL_W;

    logic              enable;
    logic [2:0]        num_ships;
    logic [GRID_W-1:0] init_grid;
    logic              place;
    logic [IDX_W-1:0]  row;
    logic [IDX_W-1:0]  col;
    logic              orient;
    logic [GRID_W-1:0] grid;
    logic              busy;
    logic              placed;
    logic              reject;
    logic [2:0]        ships_left;
    logic              done;

    modport master (
        output enable, num_ships, init_grid, place, row, col, orient,
        input  grid, busy, placed, reject, ships_left, done
    );

    modport slave (
        input  enable, num_ships, init_grid, place, row, col, orient,
        output grid, busy, placed, reject, ships_left, done
    );
endinterface
`default_nettype wire

// File: rtl/ship_placer_grid.sv
`default_nettype none
// ============================================================================
// Module   : ship_placer_grid
// Purpose  : Places a fleet of ships (lengths ships_left down to 1) on a
//            GRID_N x GRID_N board. Each request is bounds-checked, then
//            overlap-checked one cell per cycle, then written one cell per
//            cycle; every try ends in a placed or reject pulse.
// Ports    : clk   - system clock
//            reset - synchronous, active-high reset
//            bus   - ship_placer_grid_if.slave (enable, num_ships, init_grid,
//                    place, row, col, orient in; grid, busy, placed, reject,
//                    ships_left, done out)
// Config   : SHIP_VERTICAL_EN - when defined, orient=1 places ships toward
//            row 0; when undefined orient is ignored and all ships are
//            horizontal (toward col 0).
// Revision : 1.0 - initial release
// ============================================================================
module ship_placer_grid #(
    parameter int GRID_N   = 5,
    parameter int MAX_SHIP = 5
) (
    input wire clk,
    input wire reset,
    ship_placer_grid_if.slave bus
);
    localparam int CELL_W = $clog2(MAX_SHIP + 1);
    localparam int IDX_W  = $clog2(GRID_N);
    localparam int NCELL  = GRID_N * GRID_N;
    localparam int CIDX_W = $clog2(NCELL);

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_LOAD   = 3'd1,
        S_WAIT   = 3'd2,
        S_CHECK  = 3'd3,
        S_WRITE  = 3'd4,
        S_ACK    = 3'd5,
        S_REJECT = 3'd6,
        S_DONE   = 3'd7
    } state_t;

    state_t             r_state;
    logic [CELL_W-1:0]  r_cells [NCELL];
    logic [IDX_W-1:0]   r_row;
    logic [IDX_W-1:0]   r_col;
    logic [2:0]         r_k;
    logic [2:0]         r_ships_left;
    logic               r_busy;
    logic               r_placed;
    logic               r_reject;
    logic               r_done;
`ifdef SHIP_VERTICAL_EN
    logic               r_orient;
`endif

    logic               w_eff_orient;
    logic [IDX_W-1:0]   w_axis;
    logic               w_oob;
    logic [2:0]         w_load_left;
    logic [2:0]         w_len_m1;
    logic [CELL_W-1:0]  w_len_cell;
    logic [IDX_W-1:0]   w_cell_row;
    logic [IDX_W-1:0]   w_cell_col;
    logic [CIDX_W-1:0]  w_cell_idx;
    logic               w_cell_busy;

    // ------------------------------------------------------------------
    // Request qualification (evaluated on the live inputs while in WAIT)
    // ------------------------------------------------------------------
`ifdef SHIP_VERTICAL_EN
    assign w_eff_orient = bus.orient;
    assign w_axis       = bus.orient ? bus.row : bus.col;
`else
    wire w_unused_orient = bus.orient;
    assign w_eff_orient = 1'b0;
    assign w_axis       = bus.col;
`endif

    // The ship occupies anchor, anchor-1, ..., anchor-(L-1) along its axis,
    // so comparing the anchor against L-1 keeps all index math non-negative.
    assign w_oob = (int'(bus.row) >= GRID_N) ||
                   (int'(bus.col) >= GRID_N) ||
                   (int'(w_axis) < int'(r_ships_left) - 1);

    assign w_load_left = (int'(bus.num_ships) > MAX_SHIP) ? 3'(MAX_SHIP)
                                                          : bus.num_ships;
    assign w_len_m1    = r_ships_left - 3'd1;
    assign w_len_cell  = CELL_W'(r_ships_left);

    // ------------------------------------------------------------------
    // Address of cell k of the ship being checked or written
    // ------------------------------------------------------------------
    always_comb begin
        w_cell_row = r_row;
        w_cell_col = r_col - IDX_W'(r_k);
`ifdef SHIP_VERTICAL_EN
        if (r_orient) begin
            w_cell_row = r_row - IDX_W'(r_k);
            w_cell_col = r_col;
        end
`endif
        w_cell_idx = CIDX_W'(w_cell_row) * CIDX_W'(GRID_N) + CIDX_W'(w_cell_col);
    end

    assign w_cell_busy = (r_cells[w_cell_idx] != '0);

    // ------------------------------------------------------------------
    // Placement FSM
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state      <= S_IDLE;
            for (int i = 0; i < NCELL; i++) begin
                r_cells[i] <= '0;
            end
            r_row        <= '0;
            r_col        <= '0;
            r_k          <= '0;
            r_ships_left <= '0;
            r_busy       <= 1'b0;
            r_placed     <= 1'b0;
            r_reject     <= 1'b0;
            r_done       <= 1'b0;
`ifdef SHIP_VERTICAL_EN
            r_orient     <= 1'b0;
`endif
        end else if (!bus.enable) begin
            // Leaving the placement phase abandons any ship in flight;
            // the board keeps whatever has already been written.
            r_state  <= S_IDLE;
            r_busy   <= 1'b0;
            r_placed <= 1'b0;
            r_reject <= 1'b0;
            r_done   <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    r_state <= S_LOAD;
                end
                S_LOAD: begin
                    for (int i = 0; i < NCELL; i++) begin
                        r_cells[i] <= bus.init_grid[i*CELL_W +: CELL_W];
                    end
                    r_ships_left <= w_load_left;
                    if (w_load_left == 3'd0) begin
                        r_done  <= 1'b1;
                        r_state <= S_DONE;
                    end else begin
                        r_state <= S_WAIT;
                    end
                end
                S_WAIT: begin
                    if (bus.place) begin
                        r_row  <= bus.row;
                        r_col  <= bus.col;
                        r_k    <= '0;
                        r_busy <= 1'b1;
`ifdef SHIP_VERTICAL_EN
                        r_orient <= w_eff_orient;
`endif
                        if (w_oob) begin
                            r_reject <= 1'b1;
                            r_state  <= S_REJECT;
                        end else begin
                            r_state  <= S_CHECK;
                        end
                    end
                end
                S_CHECK: begin
                    if (w_cell_busy) begin
                        r_reject <= 1'b1;
                        r_state  <= S_REJECT;
                    end else if (r_k == w_len_m1) begin
                        r_k     <= '0;
                        r_state <= S_WRITE;
                    end else begin
                        r_k <= r_k + 3'd1;
                    end
                end
                S_WRITE: begin
                    r_cells[w_cell_idx] <= w_len_cell;
                    if (r_k == w_len_m1) begin
                        r_placed <= 1'b1;
                        r_state  <= S_ACK;
                    end else begin
                        r_k <= r_k + 3'd1;
                    end
                end
                S_ACK: begin
                    r_placed     <= 1'b0;
                    r_busy       <= 1'b0;
                    r_ships_left <= r_ships_left - 3'd1;
                    if (r_ships_left == 3'd1) begin
                        r_done  <= 1'b1;
                        r_state <= S_DONE;
                    end else begin
                        r_state <= S_WAIT;
                    end
                end
                S_REJECT: begin
                    r_reject <= 1'b0;
                    r_busy   <= 1'b0;
                    r_state  <= S_WAIT;
                end
                S_DONE: begin
                    r_state <= S_DONE;
                end
                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

    // ------------------------------------------------------------------
    // Outputs
    // ------------------------------------------------------------------
    for (genvar gi = 0; gi < NCELL; gi++) begin : g_pack
        assign bus.grid[gi*CELL_W +: CELL_W] = r_cells[gi];
    end

    assign bus.busy       = r_busy;
    assign bus.placed     = r_placed;
    assign bus.reject     = r_reject;
    assign bus.ships_left = r_ships_left;
    assign bus.done       = r_done;

endmodule
`default_nettype wire

// File: tb/tb_ship_placer_grid.sv
`default_nettype none
// ============================================================================
// Module   : tb_ship_placer_grid
// Purpose  : Self-checking bench for ship_placer_grid: reset, a table of
//            single-placement vectors, hand sequences for enable drop,
//            zero-ship fleets, reset mid-check and the vertical scenario,
//            then randomized fleets against a board-level reference model.
// Config   : SHIP_VERTICAL_EN selects vertical expectations.
// Revision : 1.0 - initial release
// ============================================================================
module tb_ship_placer_grid;
    localparam int GN = 5;
    localparam int MS = 5;
    localparam int CW = $clog2(MS + 1);
    localparam int IW = $clog2(GN);
    localparam int GW = GN * GN * CW;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    ship_placer_grid_if #(.GRID_N(GN), .MAX_SHIP(MS)) bus ();

    ship_placer_grid #(.GRID_N(GN), .MAX_SHIP(MS)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    int n_cmp  = 0;
    int n_fail = 0;

    // Reference board: plain 2-D array of cell values plus ships remaining.
    int mdl [GN][GN];
    int mdl_left;

    typedef struct {
        int num;
        int pre_r; int pre_c; int pre_v;
        int r; int c; int o;
        int exp_ok; int exp_lat; int exp_left;
    } vec_t;

    vec_t vecs [11];

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic logic [GW-1:0] mdl_grid();
        logic [GW-1:0] g;
        g = '0;
        for (int r = 0; r < GN; r++)
            for (int c = 0; c < GN; c++)
                g[(r*GN+c)*CW +: CW] = CW'(mdl[r][c]);
        return g;
    endfunction

    function automatic int eff_or(input int o);
`ifdef SHIP_VERTICAL_EN
        return o;
`else
        return (o == 0) ? 0 : 0;
`endif
    endfunction

    task automatic mdl_load(input logic [GW-1:0] init, input int num);
        for (int r = 0; r < GN; r++)
            for (int c = 0; c < GN; c++)
                mdl[r][c] = int'(init[(r*GN+c)*CW +: CW]);
        mdl_left = (num > MS) ? MS : num;
    endtask

    // Predicts outcome/latency of a request and applies it to the model.
    task automatic mdl_predict(input int r, input int c, input int o, output int ok, output int lat);
        int L, eo, rr, cc;
        L  = mdl_left;
        eo = eff_or(o);
        ok = 0;
        if (r >= GN || c >= GN || ((eo != 0) ? r : c) < L - 1) begin
            lat = 1;
            return;
        end
        for (int k = 0; k < L; k++) begin
            rr = (eo != 0) ? r - k : r;
            cc = (eo != 0) ? c : c - k;
            if (mdl[rr][cc] != 0) begin
                lat = k + 2;
                return;
            end
        end
        for (int k = 0; k < L; k++) begin
            rr = (eo != 0) ? r - k : r;
            cc = (eo != 0) ? c : c - k;
            mdl[rr][cc] = L;
        end
        ok = 1;
        lat = 2 * L + 1;
        mdl_left = mdl_left - 1;
    endtask

    // Drops enable, then raises it with the given fleet and board; checks
    // the load result two cycles after the enable edge.
    task automatic start_session(input int num, input logic [GW-1:0] init);
        int exp_left;
        @(negedge clk);
        bus.enable = 1'b0;
        @(negedge clk);
        bus.num_ships = 3'(num);
        bus.init_grid = init;
        bus.enable    = 1'b1;
        @(posedge clk);
        @(posedge clk);
        #1;
        exp_left = (num > MS) ? MS : num;
        chk("load_ships_left", bus.ships_left, exp_left);
        chk("load_grid", bus.grid, init);
        chk("load_done", bus.done, (exp_left == 0) ? 1 : 0);
        mdl_load(init, num);
    endtask

    // Issues one place pulse in WAIT and measures the result cycle.
    task automatic dut_place(input int r, input int c, input int o,
                             output int ok, output int lat, output int left_at_pulse);
        @(negedge clk);
        bus.row    = IW'(r);
        bus.col    = IW'(c);
        bus.orient = o[0];
        bus.place  = 1'b1;
        @(posedge clk);
        #1;
        bus.place = 1'b0;
        chk("busy_after_place", bus.busy, 1);
        ok = 0;
        lat = 0;
        left_at_pulse = 0;
        for (int j = 1; j <= 40; j++) begin
            if (j > 1) begin
                @(posedge clk);
                #1;
            end
            if (bus.placed || bus.reject) begin
                chk("pulse_exclusive", bus.placed & bus.reject, 0);
                ok = bus.placed ? 1 : 0;
                lat = j;
                left_at_pulse = int'(bus.ships_left);
                break;
            end
        end
        if (lat == 0) begin
            n_cmp++;
            n_fail++;
            $display("FAIL place_timeout: got no pulse within 40 cycles, required placed or reject");
        end
        @(posedge clk);
        #1;
    endtask

    task automatic place_and_check(input string tag, input int r, input int c, input int o,
                                   input int exp_ok, input int exp_lat, input int exp_left);
        int ok, lat, lap;
        dut_place(r, c, o, ok, lat, lap);
        chk({tag, "_outcome"}, ok, exp_ok);
        chk({tag, "_latency"}, lat, exp_lat);
        if (exp_ok != 0) chk({tag, "_left_at_pulse"}, lap, exp_left + 1);
        chk({tag, "_ships_left"}, bus.ships_left, exp_left);
        chk({tag, "_done"}, bus.done, (exp_left == 0) ? 1 : 0);
        chk({tag, "_busy_idle"}, bus.busy, 0);
        chk({tag, "_grid"}, bus.grid, mdl_grid());
    endtask

    function automatic logic [GW-1:0] cell_vec(input int r, input int c, input int v);
        logic [GW-1:0] g;
        g = '0;
        g[(r*GN+c)*CW +: CW] = CW'(v);
        return g;
    endfunction

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        int ok, lat, any_pulse;
        logic [GW-1:0] init;

        // --- reset, with enable high and a nonzero init board presented ---
        reset          = 1'b1;
        bus.enable     = 1'b1;
        bus.place      = 1'b0;
        bus.row        = '0;
        bus.col        = '0;
        bus.orient     = 1'b0;
        bus.num_ships  = 3'd3;
        bus.init_grid  = '1;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_grid", bus.grid, 0);
        chk("rst_ships_left", bus.ships_left, 0);
        chk("rst_busy", bus.busy, 0);
        chk("rst_placed", bus.placed, 0);
        chk("rst_reject", bus.reject, 0);
        chk("rst_done", bus.done, 0);
        @(negedge clk);
        reset = 1'b0;
        bus.enable = 1'b0;

        // --- table-driven single placements ---
        vecs[0]  = '{3, 0, 0, 0, 2, 4, 0, 1, 7, 2};
        vecs[1]  = '{2, 0, 0, 0, 1, 0, 0, 0, 1, 2};
        vecs[2]  = '{3, 2, 3, 1, 2, 4, 0, 0, 3, 3};
        vecs[3]  = '{3, 0, 0, 0, 5, 4, 0, 0, 1, 3};
        vecs[4]  = '{1, 0, 0, 0, 0, 0, 0, 1, 3, 0};
        vecs[5]  = '{7, 0, 0, 0, 4, 4, 0, 1, 11, 4};
        vecs[6]  = '{5, 0, 0, 0, 4, 3, 0, 0, 1, 5};
        vecs[7]  = '{2, 3, 4, 2, 3, 4, 0, 0, 2, 2};
`ifdef SHIP_VERTICAL_EN
        vecs[8]  = '{2, 0, 0, 0, 1, 0, 1, 1, 5, 1};
        vecs[9]  = '{4, 0, 0, 5, 3, 0, 1, 0, 5, 4};
`else
        vecs[8]  = '{2, 0, 0, 0, 1, 0, 1, 0, 1, 2};
        vecs[9]  = '{4, 0, 0, 5, 3, 0, 1, 0, 1, 4};
`endif
        vecs[10] = '{1, 0, 0, 0, 0, 7, 0, 0, 1, 1};

        for (int i = 0; i < 11; i++) begin
            init = (vecs[i].pre_v != 0) ? cell_vec(vecs[i].pre_r, vecs[i].pre_c, vecs[i].pre_v) : '0;
            start_session(vecs[i].num, init);
            mdl_predict(vecs[i].r, vecs[i].c, vecs[i].o, ok, lat);
            place_and_check($sformatf("vec%0d", i), vecs[i].r, vecs[i].c, vecs[i].o,
                            vecs[i].exp_ok, vecs[i].exp_lat, vecs[i].exp_left);
        end

        // --- two-ship fleet, vertical request first ---
        start_session(2, '0);
`ifdef SHIP_VERTICAL_EN
        mdl_predict(1, 0, 1, ok, lat);
        place_and_check("vert_a", 1, 0, 1, 1, 5, 1);
`else
        mdl_predict(1, 0, 1, ok, lat);
        place_and_check("vert_a", 1, 0, 1, 0, 1, 2);
        mdl_predict(1, 1, 1, ok, lat);
        place_and_check("vert_b", 1, 1, 1, 1, 5, 1);
`endif
        mdl_predict(0, 4, 0, ok, lat);
        place_and_check("vert_last", 0, 4, 0, 1, 3, 0);

        // place while DONE must be ignored
        @(negedge clk);
        bus.row = 3'd4; bus.col = 3'd4; bus.place = 1'b1;
        @(negedge clk);
        bus.place = 1'b0;
        any_pulse = 0;
        repeat (4) begin
            @(posedge clk); #1;
            if (bus.placed || bus.reject || bus.busy) any_pulse = 1;
        end
        chk("done_place_ignored", any_pulse, 0);
        chk("done_hold", bus.done, 1);
        chk("done_grid_hold", bus.grid, mdl_grid());

        // --- enable dropped in the middle of WRITE ---
        start_session(2, '0);
        @(negedge clk);
        bus.row = 3'd2; bus.col = 3'd4; bus.orient = 1'b0; bus.place = 1'b1;
        @(posedge clk); #1;
        bus.place = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        bus.enable = 1'b0;
        @(posedge clk); #1;
        chk("drop_busy", bus.busy, 0);
        chk("drop_done", bus.done, 0);
        chk("drop_placed", bus.placed, 0);
        chk("drop_partial_grid", bus.grid, cell_vec(2, 4, 2));
        @(posedge clk); #1;
        chk("drop_grid_kept", bus.grid, cell_vec(2, 4, 2));
        start_session(2, '0);

        // --- zero-ship fleet ---
        @(negedge clk);
        bus.enable = 1'b0;
        @(negedge clk);
        bus.num_ships = 3'd0;
        bus.enable = 1'b1;
        @(posedge clk); #1;
        chk("zero_done_t1", bus.done, 0);
        @(posedge clk); #1;
        chk("zero_done_t2", bus.done, 1);
        any_pulse = 0;
        repeat (4) begin
            @(posedge clk); #1;
            if (bus.placed || bus.reject) any_pulse = 1;
        end
        chk("zero_no_pulse", any_pulse, 0);

        // --- reset in the middle of CHECK ---
        start_session(3, cell_vec(0, 0, 4));
        @(negedge clk);
        bus.row = 3'd2; bus.col = 3'd4; bus.orient = 1'b0; bus.place = 1'b1;
        @(posedge clk); #1;
        bus.place = 1'b0;
        @(negedge clk);
        reset = 1'b1;
        @(posedge clk); #1;
        chk("midrst_grid", bus.grid, 0);
        chk("midrst_left", bus.ships_left, 0);
        chk("midrst_busy", bus.busy, 0);
        @(negedge clk);
        reset = 1'b0;

        // --- randomized fleets against the reference board ---
        for (int s = 0; s < 12; s++) begin
            int num, r, c, o, tries;
            init = '0;
            for (int i = 0; i < GN * GN; i++)
                if ($urandom_range(0, 5) == 0) init[i*CW +: CW] = CW'($urandom_range(1, 5));
            num = $urandom_range(1, 6);
            start_session(num, init);
            tries = 0;
            while (mdl_left > 0 && tries < 25) begin
                r = ($urandom_range(0, 9) == 0) ? 7 : $urandom_range(0, GN);
                c = ($urandom_range(0, 9) == 0) ? 7 : $urandom_range(0, GN);
                o = $urandom_range(0, 1);
                mdl_predict(r, c, o, ok, lat);
                place_and_check($sformatf("rnd%0d_%0d", s, tries), r, c, o, ok, lat, mdl_left);
                tries++;
            end
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end
endmodule
`default_nettype wire
